// File: rtl/vx_csr_pkg.sv
// vx_csr_pkg: shared state encoding, register offsets and STATUS bit positions for the Vortex CSR bank
package vx_csr_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, LAUNCH = 2'd2, RUN = 2'd3} state_e;
  localparam logic [3:0] STATUS_OFF = 4'h0;
  localparam logic [3:0] START_OFF = 4'h4;
  localparam logic [3:0] PC_OFF = 4'h8;
  localparam logic [3:0] CYCLE_OFF = 4'hC;
  localparam logic [11:0] IRQ_EN_OFF = 12'h100;
  localparam int CH_STRIDE = 16;
  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_TIMEOUT = 2;
  localparam int ST_STATE_LSB = 4;
  function automatic logic [31:0] byte_merge(input logic [31:0] cur, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b+:8] = be[b] ? nw[8*b+:8] : cur[8*b+:8];
    return r;
  endfunction
endpackage

// File: rtl/vx_core_launch_fsm.sv
// vx_core_launch_fsm: per-core launch sequencer (timed reset hold, busy wait with timeout, run cycle count)
module vx_core_launch_fsm
  import vx_csr_pkg::*;
#(
  parameter logic [31:0] PC_RESET_DEFAULT = 32'hF000_0000,
  parameter int RESET_HOLD_CYCLES = 8,
  parameter int LAUNCH_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        clr_done_i,
  input  logic        clr_timeout_i,
  input  logic        pc_we_i,
  input  logic [31:0] pc_wdata_i,
  input  logic [3:0]  pc_be_i,
  input  logic        busy_i,
  output state_e      state_o,
  output logic        done_o,
  output logic        timeout_o,
  output logic [31:0] cycle_o,
  output logic [31:0] pc_o,
  output logic        vreset_o
);
  state_e state_q, state_d;
  logic [31:0] cnt_q, cnt_d, cyc_q, cyc_d, pc_q, pc_d;
  logic done_q, done_d, to_q, to_d;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    cyc_d = cyc_q;
    done_d = done_q & ~clr_done_i;
    to_d = to_q & ~clr_timeout_i;
    pc_d = pc_we_i ? byte_merge(pc_q, pc_wdata_i, pc_be_i) : pc_q;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = HOLD;
        cnt_d = '0;
        cyc_d = '0;
        done_d = 1'b0;
        to_d = 1'b0;
      end
      HOLD: begin
        state_d = (cnt_q == 32'(RESET_HOLD_CYCLES - 1)) ? LAUNCH : HOLD;
        cnt_d = (cnt_q == 32'(RESET_HOLD_CYCLES - 1)) ? '0 : cnt_q + 32'd1;
      end
      LAUNCH: if (busy_i) state_d = RUN;
      else if (cnt_q == 32'(LAUNCH_TIMEOUT - 1)) begin
        state_d = IDLE;
        to_d = 1'b1;
      end else cnt_d = cnt_q + 32'd1;
      RUN: begin
        cyc_d = (&cyc_q) ? cyc_q : cyc_q + 32'd1;
        state_d = busy_i ? RUN : IDLE;
        done_d = busy_i ? done_d : 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      cyc_q <= '0;
      done_q <= 1'b0;
      to_q <= 1'b0;
      pc_q <= PC_RESET_DEFAULT;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      cyc_q <= cyc_d;
      done_q <= done_d;
      to_q <= to_d;
      pc_q <= pc_d;
    end
  end
  assign state_o = state_q;
  assign done_o = done_q;
  assign timeout_o = to_q;
  assign cycle_o = cyc_q;
  assign pc_o = pc_q;
  assign vreset_o = (state_q == IDLE) || (state_q == HOLD);
endmodule

// File: rtl/vx_ctrl_status_regs.sv
// vx_ctrl_status_regs: multi-core Vortex control/status register bank; define VX_CSR_IRQ_EN to add IRQ_EN and irq
module vx_ctrl_status_regs
  import vx_csr_pkg::*;
#(
  parameter int NUM_CORES = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter logic [31:0] PC_RESET_DEFAULT = 32'hF000_0000,
  parameter int RESET_HOLD_CYCLES = 8,
  parameter int LAUNCH_TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wen,
  input  logic                      ren,
  input  logic [ADDR_WIDTH-1:0]     addr,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH/8-1:0]   strobe,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic                      error,
  output logic                      request_stall,
`ifdef VX_CSR_IRQ_EN
  output logic                      irq,
`endif
  input  logic [NUM_CORES-1:0]      Vortex_busy,
  output logic [NUM_CORES-1:0]      Vortex_reset,
  output logic [NUM_CORES*32-1:0]   Vortex_PC_reset_val
);
  state_e st [16];
  logic [31:0] cyc [16];
  logic [31:0] pc [16];
  logic [15:0] dn, to, bz;
  logic [3:0] ch, off;
  logic ch_ok, is_irq, ok_wr;
  logic [31:0] sts, ien_rd;
  assign ch = addr[7:4];
  assign off = {addr[3:2], 2'b00};
  assign ch_ok = {28'd0, ch} < 32'(NUM_CORES);
  assign request_stall = 1'b0;
`ifdef VX_CSR_IRQ_EN
  logic [NUM_CORES-1:0] ien_q, ien_d;
  logic [31:0] ien_m;
  assign is_irq = addr == ADDR_WIDTH'(IRQ_EN_OFF);
  always_comb begin
    ien_m = byte_merge(32'(ien_q), wdata, strobe);
    ien_d = (ok_wr && is_irq) ? ien_m[NUM_CORES-1:0] : ien_q;
  end
  always_ff @(posedge clk) begin
    if (reset) ien_q <= '0;
    else ien_q <= ien_d;
  end
  assign ien_rd = 32'(ien_q);
  assign irq = |((dn[NUM_CORES-1:0] | to[NUM_CORES-1:0]) & ien_q);
`else
  assign is_irq = 1'b0;
  assign ien_rd = '0;
`endif
  // Write-side errors only apply to a well-formed channel address.
  assign error = (wen | ren) & ~is_irq & ((|addr[ADDR_WIDTH-1:8]) | (|addr[1:0]) | ~ch_ok |
                 (wen & ((off == CYCLE_OFF) | (((off == START_OFF) | (off == PC_OFF)) & (st[ch] != IDLE)))));
  assign ok_wr = wen & ~error;
  always_comb begin
    sts = '0;
    sts[ST_BUSY] = bz[ch];
    sts[ST_DONE] = dn[ch];
    sts[ST_TIMEOUT] = to[ch];
    sts[ST_STATE_LSB+:2] = st[ch];
    rdata = '0;
    if (ren && !wen && !error)
      rdata = is_irq ? ien_rd : (off == STATUS_OFF) ? sts : (off == PC_OFF) ? pc[ch] : (off == CYCLE_OFF) ? cyc[ch] : '0;
  end
  for (genvar c = 0; c < 16; c++) begin : g_ch
    if (c < NUM_CORES) begin : g_core
      logic sel, vr;
      assign sel = ok_wr & ~is_irq & (ch == 4'(c));
      vx_core_launch_fsm #(
        .PC_RESET_DEFAULT(PC_RESET_DEFAULT),
        .RESET_HOLD_CYCLES(RESET_HOLD_CYCLES),
        .LAUNCH_TIMEOUT(LAUNCH_TIMEOUT)
      ) u_fsm (
        .clk(clk),
        .rst(reset),
        .start_i(sel & (off == START_OFF) & wdata[0] & strobe[0]),
        .clr_done_i(sel & (off == STATUS_OFF) & strobe[0] & wdata[ST_DONE]),
        .clr_timeout_i(sel & (off == STATUS_OFF) & strobe[0] & wdata[ST_TIMEOUT]),
        .pc_we_i(sel & (off == PC_OFF)),
        .pc_wdata_i(wdata),
        .pc_be_i(strobe),
        .busy_i(Vortex_busy[c]),
        .state_o(st[c]),
        .done_o(dn[c]),
        .timeout_o(to[c]),
        .cycle_o(cyc[c]),
        .pc_o(pc[c]),
        .vreset_o(vr)
      );
      assign bz[c] = Vortex_busy[c];
      assign Vortex_reset[c] = vr;
      assign Vortex_PC_reset_val[32*c+:32] = pc[c];
    end else begin : g_pad
      assign st[c] = IDLE;
      assign cyc[c] = '0;
      assign pc[c] = '0;
      assign dn[c] = 1'b0;
      assign to[c] = 1'b0;
      assign bz[c] = 1'b0;
    end
  end
endmodule

// File: tb/tb_vx_ctrl_status_regs.sv
// tb_vx_ctrl_status_regs: randomized bus/busy traffic checked each cycle against a phase-timing model of the CSR bank
module tb_vx_ctrl_status_regs;
  localparam int NC = 2;
  localparam int H = 8;
  localparam int T = 64;
  localparam logic [31:0] PCD = 32'hF000_0000;
  logic clk = 1'b0;
  logic rst, wen, ren, error, request_stall;
  logic [31:0] addr, wdata, rdata;
  logic [3:0] strobe;
  logic [NC-1:0] busy, vreset;
  logic [NC*32-1:0] pcv;
`ifdef VX_CSR_IRQ_EN
  logic irq;
`endif
  vx_ctrl_status_regs #(.NUM_CORES(NC)) dut (
    .clk(clk), .reset(rst), .wen(wen), .ren(ren), .addr(addr), .wdata(wdata), .strobe(strobe),
    .rdata(rdata), .error(error), .request_stall(request_stall),
`ifdef VX_CSR_IRQ_EN
    .irq(irq),
`endif
    .Vortex_busy(busy), .Vortex_reset(vreset), .Vortex_PC_reset_val(pcv)
  );
  always #5 clk = ~clk;
  // Model: phase 0 idle/done, 1 reset hold, 2 waiting for busy, 3 running; cnt = cycles spent in phase.
  int ph [NC];
  int cnt [NC];
  bit dn [NC];
  bit to [NC];
  logic [31:0] cy [NC];
  logic [31:0] pc [NC];
  logic [31:0] ien;
  bit mv = 0;
  int n_cmp = 0, n_fail = 0;
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask
  function automatic bit irq_addr(input logic [31:0] a);
`ifdef VX_CSR_IRQ_EN
    return a == 32'h100;
`else
    return (a == 32'hFFFF_FFFF) && 1'b0;
`endif
  endfunction
  function automatic bit exp_err();
    int c, r;
    c = int'(addr[7:4]);
    r = int'(addr[3:2]);
    if (!(wen || ren) || irq_addr(addr)) return 0;
    if (addr[31:8] != 0 || addr[1:0] != 0 || c >= NC) return 1;
    if (!wen) return 0;
    return (r == 3) || ((r == 1 || r == 2) && ph[c] != 0);
  endfunction
  function automatic logic [31:0] exp_rd();
    int c, r;
    c = int'(addr[7:4]);
    r = int'(addr[3:2]);
    if (!ren || wen || exp_err()) return 0;
    if (irq_addr(addr)) return ien;
    if (r == 0) return 32'(busy[c]) + 2 * 32'(dn[c]) + 4 * 32'(to[c]) + 16 * 32'(ph[c]);
    if (r == 2) return pc[c];
    if (r == 3) return cy[c];
    return 0;
  endfunction
  task automatic model_step();
    bit launched [NC];
    bit e;
    int c, r;
    if (rst) begin
      for (int i = 0; i < NC; i++) begin
        ph[i] = 0; cnt[i] = 0; dn[i] = 0; to[i] = 0; cy[i] = 0; pc[i] = PCD;
      end
      ien = 0;
      mv = 1;
      return;
    end
    if (!mv) return;
    e = exp_err();
    c = int'(addr[7:4]);
    r = int'(addr[3:2]);
    for (int i = 0; i < NC; i++) launched[i] = 0;
    if (wen && !e) begin
      if (irq_addr(addr)) begin
        for (int b = 0; b < 4; b++) if (strobe[b]) ien[8*b+:8] = wdata[8*b+:8];
        ien = ien & ((32'd1 << NC) - 1);
      end else if (r == 0 && strobe[0]) begin
        if (wdata[1]) dn[c] = 0;
        if (wdata[2]) to[c] = 0;
      end else if (r == 1 && strobe[0] && wdata[0]) begin
        ph[c] = 1; cnt[c] = 0; cy[c] = 0; dn[c] = 0; to[c] = 0; launched[c] = 1;
      end else if (r == 2) begin
        for (int b = 0; b < 4; b++) if (strobe[b]) pc[c][8*b+:8] = wdata[8*b+:8];
      end
    end
    for (int i = 0; i < NC; i++) begin
      if (launched[i]) continue;
      if (ph[i] == 1) begin
        cnt[i]++;
        if (cnt[i] == H) begin ph[i] = 2; cnt[i] = 0; end
      end else if (ph[i] == 2) begin
        if (busy[i]) ph[i] = 3;
        else begin
          cnt[i]++;
          if (cnt[i] == T) begin ph[i] = 0; to[i] = 1; end
        end
      end else if (ph[i] == 3) begin
        if (cy[i] != 32'hFFFF_FFFF) cy[i]++;
        if (!busy[i]) begin ph[i] = 0; dn[i] = 1; end
      end
    end
  endtask
  task automatic cyc1();
    #1;
    if (mv) begin
      for (int i = 0; i < NC; i++) begin
        check($sformatf("vreset%0d", i), 32'(vreset[i]), 32'(ph[i] < 2));
        check($sformatf("pc%0d", i), pcv[32*i+:32], pc[i]);
      end
      check("error", 32'(error), 32'(exp_err()));
      check("rdata", rdata, exp_rd());
      check("stall", 32'(request_stall), 0);
`ifdef VX_CSR_IRQ_EN
      begin
        bit ei = 0;
        for (int i = 0; i < NC; i++) ei |= (dn[i] | to[i]) & ien[i];
        check("irq", 32'(irq), 32'(ei));
      end
`endif
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    wen = 0; ren = 0;
    repeat (n) cyc1();
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wen = 1; ren = 0; addr = a; wdata = d; strobe = s;
    cyc1();
    wen = 0;
  endtask
  task automatic rdc(input logic [31:0] a, input logic [31:0] exp, input string nm);
    wen = 0; ren = 1; addr = a;
    #1 check(nm, rdata, exp);
    cyc1();
    ren = 0;
  endtask
  task automatic errc(input bit w, input logic [31:0] a, input string nm);
    wen = w; ren = !w; addr = a; wdata = 32'h1; strobe = 4'hF;
    #1 check(nm, 32'(error), 1);
    cyc1();
    wen = 0; ren = 0;
  endtask
  logic [31:0] atab [12] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h20, 32'h2, 32'h100, 32'h204};
  initial begin
    int hi, k, r;
    rst = 1; wen = 0; ren = 0; addr = 0; wdata = 0; strobe = 0; busy = 0;
    @(negedge clk);
    idle(2);
    rst = 0;
    #1;
    check("rst_vreset", 32'(vreset), 32'h3);
    check("rst_pc0", pcv[31:0], 32'hF000_0000);
    check("rst_pc1", pcv[63:32], 32'hF000_0000);
    check("rst_error", 32'(error), 0);
    rdc(32'h0, 32'h0, "rst_status0");
    rdc(32'h10, 32'h0, "rst_status1");
    wr(32'h18, 32'h8000_0000, 4'hF);
    rdc(32'h18, 32'h8000_0000, "pc1_rb");
    wr(32'h14, 32'h1, 4'hF);
    hi = 0;
    while (vreset[1] && hi < 20) begin
      check("ch0_unaffected", 32'(vreset[0]), 1);
      cyc1();
      hi++;
    end
    check("hold_len", hi, 8);
    wr(32'h4, 32'h1, 4'hF);
    idle(H);
    busy[0] = 1;
    idle(100);
    busy[0] = 0;
    idle(1);
    rdc(32'h0, 32'h2, "run_done");
    rdc(32'hC, 32'd100, "run_cycles");
    wr(32'h0, 32'h2, 4'hF);
    rdc(32'h0, 32'h0, "done_w1c");
    wr(32'h4, 32'h1, 4'hF);
    idle(H);
    idle(T - 1);
    check("launch_rst_low", 32'(vreset[0]), 0);
    idle(1);
    rdc(32'h0, 32'h4, "timeout_status");
    check("timeout_vreset", 32'(vreset[0]), 1);
    wr(32'h4, 32'h1, 4'hF);
    idle(H);
    busy[0] = 1;
    idle(2);
    errc(1, 32'h4, "err_start_run");
    errc(1, 32'hC, "err_wr_cycle");
    errc(0, 32'h20, "err_rd_ch2");
    errc(0, 32'h2, "err_rd_unaligned");
    errc(1, 32'h8, "err_pc_run");
    rdc(32'h0, 32'h31, "run_unchanged");
    rdc(32'h8, 32'hF000_0000, "pc_unchanged");
    busy[0] = 0;
    idle(1);
    wr(32'h0, 32'h6, 4'hF);
    wr(32'h8, 32'h0000_AB00, 4'b0010);
    rdc(32'h8, 32'hF000_AB00, "pc_strobe");
`ifdef VX_CSR_IRQ_EN
    wr(32'h100, 32'h1, 4'hF);
    rdc(32'h100, 32'h1, "irq_en_rb");
    check("irq_idle", 32'(irq), 0);
    wr(32'h4, 32'h1, 4'hF);
    idle(H);
    busy[0] = 1;
    idle(3);
    busy[0] = 0;
    idle(1);
    check("irq_set", 32'(irq), 1);
    wr(32'h0, 32'h2, 4'hF);
    check("irq_clr", 32'(irq), 0);
`else
    errc(0, 32'h100, "err_irq_absent");
`endif
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 999) == 0);
      for (int c = 0; c < NC; c++) if ($urandom_range(0, 15) == 0) busy[c] = ~busy[c];
      k = $urandom_range(0, 11);
      r = $urandom_range(0, 5);
      addr = atab[k];
      wen = (r == 1 || r == 3);
      ren = (r == 2 || r == 3);
      wdata = $urandom;
      strobe = $urandom_range(0, 1) ? 4'hF : 4'($urandom_range(0, 15));
      cyc1();
    end
    rst = 0;
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/vx_ctrl_status_regs.md
Name: vx_ctrl_status_regs

Overview:
- Parametrised successor to the single-core busy/start/PC-reset register set in the Vortex wrapper.
- Exposes NUM_CORES independent control channels on one bus_protocol_if peripheral_vital port.
- Each channel has a launch FSM that drives Vortex reset (timed hold), tracks busy, counts run cycles, and flags done/timeout.
- Sits between the AHB subordinate and one or more Vortex instances.

Parameters:
- NUM_CORES, 2, number of independent channels (1..16).
- DATA_WIDTH, 32, bus data width (fixed 32).
- ADDR_WIDTH, 32, bus offset address width.
- PC_RESET_DEFAULT, 32'hF000_0000, reset value of every PC_RESET_VAL register.
- RESET_HOLD_CYCLES, 8, cycles Vortex_reset stays high after START (minimum 1).
- LAUNCH_TIMEOUT, 64, max cycles to wait for busy to rise after reset release.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- wen  in  1  bus write request
- ren  in  1  bus read request
- addr  in  ADDR_WIDTH  offset address
- wdata  in  DATA_WIDTH  write data
- strobe  in  DATA_WIDTH/8  byte enables
- rdata  out  DATA_WIDTH  read data
- error  out  1  bus error
- request_stall  out  1  wait-state request (always 0)
- Vortex_busy  in  NUM_CORES  per-core busy
- Vortex_reset  out  NUM_CORES  per-core reset to Vortex
- Vortex_PC_reset_val  out  NUM_CORES*32  per-core start PC, core i at [32i+31:32i]

Behaviour:
- Reset is synchronous and active-high, sampled on the rising edge of clk. When reset is high at an edge, all of the following load:
  - state=IDLE
  - Vortex_reset all 1
  - PC regs = PC_RESET_DEFAULT
  - done, timeout, counters = 0
- rdata and error are combinational and evaluate to 0 whenever ren and wen are both 0.
- Address map: channel stride 0x10; ch = addr[7:4], reg = addr[3:2].
  - 0x0 STATUS (read): bit0 live busy, bit1 done, bit2 timeout, bits[5:4] state.
  - 0x0 STATUS (write): W1C on bits 1 and 2.
  - 0x4 START: write wdata[0]=1 with strobe[0]=1 launches; reads return 0.
  - 0x8 PC_RESET_VAL: RW, honours byte strobes.
  - 0xC CYCLE_COUNT: RO; a write raises error.
- error=1 in the same cycle for any of:
  - ch >= NUM_CORES;
  - addr[1:0] != 0;
  - addr[ADDR_WIDTH-1:8] != 0;
  - write to CYCLE_COUNT;
  - START while state is HOLD, LAUNCH or RUN (the write is ignored);
  - PC_RESET_VAL write while state is not IDLE or DONE (the write is ignored).
- Any error-qualified write has no side effect. wen and ren both high is treated as a write.
- FSM per channel. Encoding: IDLE=0, HOLD=1, LAUNCH=2, RUN=3; DONE shares encoding 0 and is distinguished by done/timeout.
  - IDLE/DONE: Vortex_reset=1.
    - Valid START → HOLD.
    - On entering HOLD: hold counter=0, CYCLE_COUNT=0, done=0, timeout=0.
  - HOLD: Vortex_reset=1; counter increments each cycle. At RESET_HOLD_CYCLES-1 → LAUNCH; Vortex_reset is high for exactly RESET_HOLD_CYCLES cycles.
  - LAUNCH: Vortex_reset=0; counter counts again from 0.
    - Busy=1 → RUN.
    - Counter reaches LAUNCH_TIMEOUT-1 with busy still 0 → DONE with timeout=1.
  - RUN: Vortex_reset=0; CYCLE_COUNT increments every cycle and saturates at 32'hFFFF_FFFF.
    - Busy falling to 0 → DONE with done=1. CYCLE_COUNT then holds.
- Simultaneous events:
  - Hardware set of done/timeout in the same cycle as a W1C → set wins.
  - Busy that is already high in the first LAUNCH cycle → RUN on the next edge.
- Channels are fully independent; no shared arbitration.
- Vortex_PC_reset_val is driven directly from the registers.

Optional Feature:
- Macro VX_CSR_IRQ_EN.
- When defined:
  - Adds output irq (1 bit) = OR over channels of (done|timeout) & irq_en.
  - Adds RW register 0x100 IRQ_EN with bit i = channel i enable; reset value 0.
  - Address 0x100 is exempt from the upper-address error check.
- When undefined: no irq port, and 0x100 returns error.

Decomposition:
- Package vx_csr_pkg:
  - state enum (IDLE, HOLD, LAUNCH, RUN);
  - register offset localparams (STATUS_OFF, START_OFF, PC_OFF, CYCLE_OFF, IRQ_EN_OFF);
  - CH_STRIDE=0x10;
  - STATUS bit-position constants.
- Sub-module vx_core_launch_fsm: one instance per channel via generate. Owns the state, counters, done/timeout and PC register. Top level holds address decode, error logic, rdata mux and optional IRQ logic.

Test Plan:
- Reset check, NUM_CORES=2: hold reset 2 cycles → Vortex_reset=2'b11, both PCs=0xF000_0000, STATUS read=0, error=0, request_stall=0.
- PC write and launch: write 0x18=0x8000_0000 with strobe 4'hF → reads back 0x8000_0000. Then write 0x14=1 → Vortex_reset[1] high for exactly 8 cycles then 0. Channel 0 is unaffected.
- Normal run: after launch, raise busy[0] for 100 cycles, then drop → STATUS(0x0) bit1=1 and CYCLE_COUNT(0xC)=100. Write 0x0=0x2 → done clears.
- Timeout: launch channel 0 and never raise busy → 64 cycles after reset release, STATUS=0x4 and Vortex_reset[0]=1.
- Error cases, each → error=1 and state unchanged:
  - START to channel 0 during RUN;
  - write to 0xC;
  - read 0x20 with NUM_CORES=2;
  - read 0x02.
- Byte strobes and IRQ: with VX_CSR_IRQ_EN, write PC with strobe 4'b0010, wdata 0x0000_AB00 → PC=0xF000_AB00. Set IRQ_EN=1 and complete a run → irq=1. W1C done → irq=0.
